// File: rtl/instr_packer_if.sv
// Instruction handshake and memory write port of the instruction packer.
// The slave modport is the packer's view; master is the producer/memory side.
interface instr_packer_if;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned WORD_W = 16;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_opcode;
    logic [ADDR_W-1:0] in_address;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;

    modport master (
        output in_valid, in_opcode, in_address, in_last, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_opcode, in_address, in_last, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_packer.sv
// Buffers opcode/address pairs in a small FIFO and writes them as packed
// 16-bit instruction words to consecutive memory addresses.
module instr_packer #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [11:0] START_ADDR = 12'h000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    instr_packer_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic          wrapped
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        last;
        logic [3:0]  opcode;
        logic [11:0] address;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t           state, state_nx;
    entry_t           fifo [DEPTH];
    entry_t           in_entry;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [CNT_W-1:0] count, count_nx, remain;
    logic             last_acc, last_acc_nx, ready_nx;
    logic             push, pop;
    logic [15:0]      head_word_nx;

    assign in_entry = '{last: bus.in_last, opcode: bus.in_opcode, address: bus.in_address};
    assign push     = bus.in_valid && bus.in_ready;
    assign pop      = (state == WRITE) && bus.mem_ack;

    // Next-cycle view of FIFO, FSM and handshake so outputs can be registered
    always_comb begin
        rd_ptr_nx    = rd_ptr + PTR_W'(pop);
        remain       = count - CNT_W'(pop);
        count_nx     = remain + CNT_W'(push);
        state_nx     = state;
        last_acc_nx  = last_acc || (push && bus.in_last);
        head_word_nx = {fifo[rd_ptr_nx].opcode, fifo[rd_ptr_nx].address};
        if (remain == '0) begin
            head_word_nx = {bus.in_opcode, bus.in_address};
        end
        case (state)
            IDLE:    if (count_nx != '0) state_nx = WRITE;
            WRITE: begin
                if (pop) begin
                    if (fifo[rd_ptr].last)   state_nx = DONE;
                    else if (count_nx != '0) state_nx = WRITE;
                    else                     state_nx = IDLE;
                end
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (clear) begin
            state_nx    = IDLE;
            count_nx    = '0;
            last_acc_nx = 1'b0;
        end
        ready_nx = (count_nx != CNT_W'(DEPTH)) && (state_nx != DONE) && !last_acc_nx;
    end

    // FIFO payload storage; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            fifo[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            last_acc      <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= START_ADDR;
            bus.mem_wdata <= 16'h0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            wrapped       <= 1'b0;
        end else begin
            state        <= state_nx;
            count        <= count_nx;
            last_acc     <= last_acc_nx;
            bus.in_ready <= ready_nx;
            bus.mem_we   <= (state_nx == WRITE);
            busy         <= (count_nx != '0) || (state_nx == WRITE);
            done         <= (state_nx == DONE);
            if (state_nx == WRITE) begin
                bus.mem_wdata <= head_word_nx;
            end
            if (clear) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                bus.mem_addr <= START_ADDR;
                wrapped      <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) begin
                    rd_ptr       <= rd_ptr_nx;
                    bus.mem_addr <= bus.mem_addr + 12'd1;
                    if (bus.mem_addr == 12'hFFF) wrapped <= 1'b1;
                end
            end
        end
    end
endmodule
